// File: rtl/l1_assoc_cache.sv
// l1_assoc_cache: set-associative L1 with round-robin victims, dirty writeback and MSI coherence.
// Define L1_ASSOC_EXCL_EN to build the MESI variant (Exclusive state on unshared RD fills).
module l1_assoc_cache #(
  parameter int unsigned LINE_ADDR_BITS = 26,
  parameter int unsigned LINE_BITS      = 512,
  parameter int unsigned SETS           = 16,
  parameter int unsigned WAYS           = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_valid,
  input  logic                      cpu_command,
  input  logic [LINE_ADDR_BITS-1:0] cpu_addr,
  input  logic [LINE_BITS-1:0]      cpu_write_data,
  output logic                      cpu_ready,
  output logic                      cpu_read_valid,
  output logic [LINE_BITS-1:0]      cpu_read_data,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic [LINE_ADDR_BITS-1:0] bus_req_addr,
  output logic [1:0]                bus_req,
  output logic [LINE_BITS-1:0]      bus_req_data,
  input  logic                      bus_resp_valid,
  input  logic [LINE_BITS-1:0]      bus_resp_data,
  input  logic                      bus_resp_shared,
  input  logic                      snoop_valid,
  input  logic [LINE_ADDR_BITS-1:0] snoop_addr,
  input  logic [1:0]                snoop_req,
  output logic                      snoop_shared,
  output logic [LINE_BITS-1:0]      snoop_data
);
  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned TAG_BITS = LINE_ADDR_BITS - IDX_BITS;
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {LS_I, LS_S, LS_E, LS_M} line_st_e;
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB} bus_req_e;
  typedef enum logic [2:0] {ST_IDLE, ST_WB_REQ, ST_WB_WAIT, ST_REQ, ST_WAIT, ST_DONE} fsm_e;

  line_st_e                  lst_q  [SETS][WAYS];
  line_st_e                  lst_d  [SETS][WAYS];
  logic [TAG_BITS-1:0]       tag_q  [SETS][WAYS];
  logic [TAG_BITS-1:0]       tag_d  [SETS][WAYS];
  logic [LINE_BITS-1:0]      data_q [SETS][WAYS];
  logic [LINE_BITS-1:0]      data_d [SETS][WAYS];
  logic [WAY_BITS-1:0]       rr_q   [SETS];
  logic [WAY_BITS-1:0]       rr_d   [SETS];

  fsm_e                      fsm_q, fsm_d;
  logic [LINE_ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
  logic                      pend_cmd_q, pend_cmd_d;
  logic [LINE_BITS-1:0]      pend_wdata_q, pend_wdata_d;
  logic [WAY_BITS-1:0]       pend_way_q, pend_way_d;

  logic                      cpu_ready_q, cpu_ready_d;
  logic                      cpu_read_valid_q, cpu_read_valid_d;
  logic [LINE_BITS-1:0]      cpu_read_data_q, cpu_read_data_d;
  logic                      bus_req_valid_q, bus_req_valid_d;
  logic [LINE_ADDR_BITS-1:0] bus_req_addr_q, bus_req_addr_d;
  bus_req_e                  bus_req_type_q, bus_req_type_d;
  logic [LINE_BITS-1:0]      bus_req_data_q, bus_req_data_d;
  logic                      snoop_shared_q, snoop_shared_d;
  logic [LINE_BITS-1:0]      snoop_data_q, snoop_data_d;

  logic [IDX_BITS-1:0]       cpu_idx, snp_idx, pend_idx, pend_idx_d;
  logic [TAG_BITS-1:0]       cpu_tag, snp_tag, pend_tag;
  logic                      hit, inv_found, snp_hit, fill_excl;
  logic [WAY_BITS-1:0]       hit_way, inv_way, victim, snp_way;

  assign cpu_idx  = cpu_addr[IDX_BITS-1:0];
  assign cpu_tag  = cpu_addr[LINE_ADDR_BITS-1:IDX_BITS];
  assign snp_idx  = snoop_addr[IDX_BITS-1:0];
  assign snp_tag  = snoop_addr[LINE_ADDR_BITS-1:IDX_BITS];
  assign pend_idx = pend_addr_q[IDX_BITS-1:0];
  assign pend_tag = pend_addr_q[LINE_ADDR_BITS-1:IDX_BITS];

`ifdef L1_ASSOC_EXCL_EN
  assign fill_excl = ~bus_resp_shared;
`else
  assign fill_excl = bus_resp_shared & 1'b0;
`endif

  always_comb begin
    fsm_d            = fsm_q;
    lst_d            = lst_q;
    tag_d            = tag_q;
    data_d           = data_q;
    rr_d             = rr_q;
    pend_addr_d      = pend_addr_q;
    pend_cmd_d       = pend_cmd_q;
    pend_wdata_d     = pend_wdata_q;
    pend_way_d       = pend_way_q;
    cpu_read_valid_d = 1'b0;
    cpu_read_data_d  = '0;
    bus_req_type_d   = bus_req_type_q;
    bus_req_addr_d   = bus_req_addr_q;
    bus_req_data_d   = bus_req_data_q;
    snoop_shared_d   = 1'b0;
    snoop_data_d     = '0;
    hit              = 1'b0;
    hit_way          = '0;
    inv_found        = 1'b0;
    inv_way          = '0;
    victim           = '0;
    snp_hit          = 1'b0;
    snp_way          = '0;

    for (int unsigned w = 0; w < WAYS; w++) begin
      if (lst_q[cpu_idx][WAY_BITS'(w)] != LS_I && tag_q[cpu_idx][WAY_BITS'(w)] == cpu_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (lst_q[cpu_idx][WAY_BITS'(w - 1)] == LS_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w - 1);
      end
    end

    case (fsm_q)
      ST_IDLE: begin
        if (cpu_valid && cpu_ready_q) begin
          pend_addr_d  = cpu_addr;
          pend_cmd_d   = cpu_command;
          pend_wdata_d = cpu_write_data;
          if (hit) begin
            if (!cpu_command) begin
              cpu_read_valid_d = 1'b1;
              cpu_read_data_d  = data_q[cpu_idx][hit_way];
            end else if (lst_q[cpu_idx][hit_way] == LS_S) begin
              pend_way_d     = hit_way;
              fsm_d          = ST_REQ;
              bus_req_type_d = BUS_UPGR;
              bus_req_addr_d = cpu_addr;
              bus_req_data_d = '0;
            end else begin
              data_d[cpu_idx][hit_way] = cpu_write_data;
              lst_d[cpu_idx][hit_way]  = LS_M;
            end
          end else begin
            victim = inv_found ? inv_way : rr_q[cpu_idx];
            if (!inv_found) begin
              rr_d[cpu_idx] = (rr_q[cpu_idx] == WAY_BITS'(WAYS - 1)) ? '0 : rr_q[cpu_idx] + 1'b1;
            end
            pend_way_d = victim;
            if (lst_q[cpu_idx][victim] == LS_M) begin
              fsm_d          = ST_WB_REQ;
              bus_req_type_d = BUS_WB;
              bus_req_addr_d = {tag_q[cpu_idx][victim], cpu_idx};
              bus_req_data_d = data_q[cpu_idx][victim];
            end else begin
              fsm_d          = ST_REQ;
              bus_req_type_d = cpu_command ? BUS_RDX : BUS_RD;
              bus_req_addr_d = cpu_addr;
              bus_req_data_d = '0;
            end
          end
        end
      end
      ST_WB_REQ: begin
        if (bus_req_ready) begin
          fsm_d          = ST_WB_WAIT;
          bus_req_data_d = '0;
        end
      end
      ST_WB_WAIT: begin
        if (bus_resp_valid) begin
          lst_d[pend_idx][pend_way_q] = LS_I;
          fsm_d          = ST_REQ;
          bus_req_type_d = pend_cmd_q ? BUS_RDX : BUS_RD;
          bus_req_addr_d = pend_addr_q;
          bus_req_data_d = '0;
        end
      end
      ST_REQ: begin
        if (bus_req_ready) fsm_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_resp_valid) begin
          tag_d[pend_idx][pend_way_q] = pend_tag;
          if (bus_req_type_q == BUS_RD) begin
            data_d[pend_idx][pend_way_q] = bus_resp_data;
            lst_d[pend_idx][pend_way_q]  = fill_excl ? LS_E : LS_S;
          end else begin
            data_d[pend_idx][pend_way_q] = pend_wdata_q;
            lst_d[pend_idx][pend_way_q]  = LS_M;
          end
          cpu_read_valid_d = ~pend_cmd_q;
          cpu_read_data_d  = pend_cmd_q ? '0 : bus_resp_data;
          fsm_d            = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase

    // Snoop looks up the post-controller arrays so same-cycle updates land first.
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (snoop_valid && lst_d[snp_idx][WAY_BITS'(w)] != LS_I &&
          tag_d[snp_idx][WAY_BITS'(w)] == snp_tag) begin
        snp_hit = 1'b1;
        snp_way = WAY_BITS'(w);
      end
    end
    if (snp_hit && snoop_req != BUS_WB) begin
      snoop_shared_d = 1'b1;
      if (lst_d[snp_idx][snp_way] == LS_M) snoop_data_d = data_d[snp_idx][snp_way];
      lst_d[snp_idx][snp_way] = (snoop_req == BUS_RD) ? LS_S : LS_I;
    end

    // An ungranted UPGR whose S copy was just invalidated must fetch the line instead.
    pend_idx_d = pend_addr_d[IDX_BITS-1:0];
    if (fsm_d == ST_REQ && bus_req_type_d == BUS_UPGR && lst_d[pend_idx_d][pend_way_d] == LS_I) begin
      bus_req_type_d = BUS_RDX;
    end

    cpu_ready_d     = (fsm_d == ST_IDLE);
    bus_req_valid_d = (fsm_d == ST_REQ) || (fsm_d == ST_WB_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q            <= ST_IDLE;
      lst_q            <= '{default: LS_I};
      rr_q             <= '{default: '0};
      pend_addr_q      <= '0;
      pend_cmd_q       <= 1'b0;
      pend_wdata_q     <= '0;
      pend_way_q       <= '0;
      cpu_ready_q      <= 1'b0;
      cpu_read_valid_q <= 1'b0;
      cpu_read_data_q  <= '0;
      bus_req_valid_q  <= 1'b0;
      bus_req_addr_q   <= '0;
      bus_req_type_q   <= BUS_RD;
      bus_req_data_q   <= '0;
      snoop_shared_q   <= 1'b0;
      snoop_data_q     <= '0;
    end else begin
      fsm_q            <= fsm_d;
      lst_q            <= lst_d;
      rr_q             <= rr_d;
      pend_addr_q      <= pend_addr_d;
      pend_cmd_q       <= pend_cmd_d;
      pend_wdata_q     <= pend_wdata_d;
      pend_way_q       <= pend_way_d;
      cpu_ready_q      <= cpu_ready_d;
      cpu_read_valid_q <= cpu_read_valid_d;
      cpu_read_data_q  <= cpu_read_data_d;
      bus_req_valid_q  <= bus_req_valid_d;
      bus_req_addr_q   <= bus_req_addr_d;
      bus_req_type_q   <= bus_req_type_d;
      bus_req_data_q   <= bus_req_data_d;
      snoop_shared_q   <= snoop_shared_d;
      snoop_data_q     <= snoop_data_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_ready      = cpu_ready_q;
  assign cpu_read_valid = cpu_read_valid_q;
  assign cpu_read_data  = cpu_read_data_q;
  assign bus_req_valid  = bus_req_valid_q;
  assign bus_req_addr   = bus_req_addr_q;
  assign bus_req        = bus_req_type_q;
  assign bus_req_data   = bus_req_data_q;
  assign snoop_shared   = snoop_shared_q;
  assign snoop_data     = snoop_data_q;
endmodule

// File: tb/tb_l1_assoc_cache.sv
// Directed bench for l1_assoc_cache: hits, misses, writeback/round-robin, upgrade, snoops, reset.
module tb_l1_assoc_cache;
  localparam int unsigned LAB = 26;
  localparam int unsigned LB  = 512;
  localparam logic [1:0] RD = 2'd0, RDX = 2'd1, UPGR = 2'd2, WB = 2'd3;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_valid, cpu_command;
  logic [LAB-1:0] cpu_addr;
  logic [LB-1:0]  cpu_write_data;
  logic           cpu_ready, cpu_read_valid;
  logic [LB-1:0]  cpu_read_data;
  logic           bus_req_valid, bus_req_ready;
  logic [LAB-1:0] bus_req_addr;
  logic [1:0]     bus_req;
  logic [LB-1:0]  bus_req_data;
  logic           bus_resp_valid, bus_resp_shared;
  logic [LB-1:0]  bus_resp_data;
  logic           snoop_valid;
  logic [LAB-1:0] snoop_addr;
  logic [1:0]     snoop_req;
  logic           snoop_shared;
  logic [LB-1:0]  snoop_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  l1_assoc_cache #(.LINE_ADDR_BITS(LAB), .LINE_BITS(LB), .SETS(16), .WAYS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_command(cpu_command), .cpu_addr(cpu_addr),
    .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready),
    .cpu_read_valid(cpu_read_valid), .cpu_read_data(cpu_read_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req(bus_req), .bus_req_data(bus_req_data),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_resp_shared(bus_resp_shared),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_req(snoop_req),
    .snoop_shared(snoop_shared), .snoop_data(snoop_data)
  );

  always #5 clk = ~clk;

  function automatic logic [LB-1:0] ln(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic cmd, input logic [LAB-1:0] addr, input logic [LB-1:0] wd);
    int unsigned n = 0;
    while (!cpu_ready && n < 20) begin
      tick();
      n++;
    end
    check("cpu_ready_wait", cpu_ready, 1'b1);
    cpu_valid = 1'b1; cpu_command = cmd; cpu_addr = addr; cpu_write_data = wd;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [1:0] typ, input logic [LAB-1:0] addr,
                            input logic [LB-1:0] data);
    int unsigned n = 0;
    while (!bus_req_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus_req_valid, 1'b1);
    check({tag, "_type"}, bus_req, typ);
    check({tag, "_addr"}, bus_req_addr, addr);
    check({tag, "_data"}, bus_req_data, data);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [LB-1:0] data, input logic shared);
    bus_resp_valid = 1'b1; bus_resp_data = data; bus_resp_shared = shared;
    tick();
    bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_shared = 1'b0;
  endtask

  task automatic snoop(input string tag, input logic [1:0] typ, input logic [LAB-1:0] addr,
                       input logic exp_sh, input logic [LB-1:0] exp_data);
    snoop_valid = 1'b1; snoop_addr = addr; snoop_req = typ;
    tick();
    snoop_valid = 1'b0;
    check({tag, "_shared"}, snoop_shared, exp_sh);
    check({tag, "_data"}, snoop_data, exp_data);
    tick();
    check({tag, "_shared_drop"}, snoop_shared, 1'b0);
  endtask

  task automatic load_miss(input string tag, input logic [LAB-1:0] addr, input logic [LB-1:0] fill,
                           input logic shared);
    cpu_req(1'b0, addr, '0);
    expect_req(tag, RD, addr, '0);
    respond(fill, shared);
    check({tag, "_rvalid"}, cpu_read_valid, 1'b1);
    check({tag, "_rdata"}, cpu_read_data, fill);
  endtask

  task automatic load_hit(input string tag, input logic [LAB-1:0] addr, input logic [LB-1:0] exp);
    cpu_req(1'b0, addr, '0);
    check({tag, "_rvalid"}, cpu_read_valid, 1'b1);
    check({tag, "_rdata"}, cpu_read_data, exp);
    check({tag, "_nobus"}, bus_req_valid, 1'b0);
  endtask

  // After the fill response of a store: DONE for one cycle, then ready again.
  task automatic store_done(input string tag);
    check({tag, "_rvalid"}, cpu_read_valid, 1'b0);
    check({tag, "_busy"}, cpu_ready, 1'b0);
    tick();
    check({tag, "_ready"}, cpu_ready, 1'b1);
  endtask

  task automatic store_miss(input string tag, input logic [LAB-1:0] addr, input logic [LB-1:0] wd);
    cpu_req(1'b1, addr, wd);
    expect_req(tag, RDX, addr, '0);
    respond(ln(32'h0BADF00D), 1'b0);
    store_done(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cpu_valid = 1'b0; cpu_command = 1'b0; cpu_addr = '0; cpu_write_data = '0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0; bus_resp_shared = 1'b0;
    snoop_valid = 1'b0; snoop_addr = '0; snoop_req = 2'd0;
    tick();
    tick();
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_bus_valid", bus_req_valid, 1'b0);
    check("rst_rvalid", cpu_read_valid, 1'b0);
    check("rst_bus_req", bus_req, 2'd0);
    check("rst_bus_addr", bus_req_addr, '0);
    check("rst_snoop_shared", snoop_shared, 1'b0);
    check("rst_snoop_data", snoop_data, '0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", cpu_ready, 1'b1);

    // Load miss then hit on set 0
    load_miss("ld40", 26'h40, ln(32'hAAAAAAAA), 1'b1);
    load_hit("hit40", 26'h40, ln(32'hAAAAAAAA));

    // Store hit on S -> UPGR, then snoop RD supplies the dirty line
    load_miss("ld10", 26'h10, ln(32'h11111111), 1'b1);
    cpu_req(1'b1, 26'h10, ln(32'h5A5A0001));
    expect_req("upg10", UPGR, 26'h10, '0);
    respond(ln(32'h0), 1'b1);
    store_done("upg10");
    snoop("snp_rd10", RD, 26'h10, 1'b1, ln(32'h5A5A0001));

    // Line is S again: UPGR pending, snoop RDX invalidates it -> re-issued as RDX
    cpu_req(1'b1, 26'h10, ln(32'hC0DE0002));
    check("upg10b_valid", bus_req_valid, 1'b1);
    check("upg10b_type", bus_req, UPGR);
    snoop("snp_rdx10", RDX, 26'h10, 1'b1, '0);
    expect_req("reissue10", RDX, 26'h10, '0);
    respond(ln(32'hBADBAD00), 1'b0);
    store_done("reissue10");
    load_hit("hit10", 26'h10, ln(32'hC0DE0002));
    snoop("snp_rd10b", RD, 26'h10, 1'b1, ln(32'hC0DE0002));

    // Fill set 1 with four dirty lines, then a fifth store evicts way 0
    for (int i = 0; i < 4; i++) begin
      store_miss($sformatf("st%0d", i), 26'h41 + 26'(i * 16), ln(32'hD0000000 + 32'(i)));
    end
    cpu_req(1'b1, 26'h81, ln(32'hD0000004));
    expect_req("wb41", WB, 26'h41, ln(32'hD0000000));
    respond('0, 1'b0);
    expect_req("rdx81", RDX, 26'h81, '0);
    respond(ln(32'h0BADF00D), 1'b0);
    store_done("rdx81");
    // Pointer advanced to way 1: next miss evicts 0x51
    cpu_req(1'b0, 26'h91, '0);
    expect_req("wb51", WB, 26'h51, ln(32'hD0000001));
    respond('0, 1'b0);
    expect_req("rd91", RD, 26'h91, '0);
    respond(ln(32'h91919191), 1'b1);
    check("rd91_rvalid", cpu_read_valid, 1'b1);
    check("rd91_rdata", cpu_read_data, ln(32'h91919191));
    load_hit("hit81", 26'h81, ln(32'hD0000004));
    load_hit("hit61", 26'h61, ln(32'hD0000002));

    // Unshared RD fill then store: silent in MESI, UPGR in MSI
    load_miss("ld22", 26'h22, ln(32'h22222222), 1'b0);
    cpu_req(1'b1, 26'h22, ln(32'hE0E0E0E0));
`ifdef L1_ASSOC_EXCL_EN
    check("silent_store_nobus", bus_req_valid, 1'b0);
    check("silent_store_ready", cpu_ready, 1'b1);
    tick();
    check("silent_store_nobus2", bus_req_valid, 1'b0);
`else
    expect_req("upg22", UPGR, 26'h22, '0);
    respond('0, 1'b1);
    store_done("upg22");
`endif
    load_hit("hit22", 26'h22, ln(32'hE0E0E0E0));

    // Reset while a request is pending, then while waiting for the response
    cpu_req(1'b0, 26'h34, '0);
    check("req34_valid", bus_req_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_req_valid", bus_req_valid, 1'b0);
    check("rst_req_ready", cpu_ready, 1'b0);
    reset = 1'b0;
    tick();
    cpu_req(1'b0, 26'h33, '0);
    expect_req("ld33", RD, 26'h33, '0);
    reset = 1'b1;
    tick();
    check("rst_wait_valid", bus_req_valid, 1'b0);
    check("rst_wait_ready", cpu_ready, 1'b0);
    check("rst_wait_rvalid", cpu_read_valid, 1'b0);
    reset = 1'b0;
    tick();
    check("rst_wait_release", cpu_ready, 1'b1);
    load_miss("ld33b", 26'h33, ln(32'h33333333), 1'b1);
    load_miss("ld40b", 26'h40, ln(32'h40404040), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
